array_pair_responder: RTL and testbench

Memory-side responder for the array-copy engine. It holds the 10×4 source array M and the 10×4 destination array N. It answers the copier's combinational M[I] reads and captures its N[J] <= M[I] writes. It also provides a serial load port for M and a handshaked dump port that streams N out. It sits between the copy FSM (which drives I, J and Ns_of_J_Write) and the test/host side.

---
 rtl/array_pair_responder_pkg.sv | 16 +
 rtl/array_pair_responder_reg_file.sv | 24 ++
 rtl/array_pair_responder.sv | 153 +++++++++++++++
 tb/tb_array_pair_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_pair_responder_pkg.sv
// Shared constants and FSM encoding for the
// array-copy memory-side responder.
package array_pair_responder_pkg;

  localparam int DEPTH = 10;
  localparam int WIDTH = 4;
  localparam logic [3:0] LAST_IDX = 4'd9;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    SERVE = 4'b0100,
    DUMP  = 4'b1000
  } state_t;

endpackage

// File: rtl/array_pair_responder_reg_file.sv
// 10x4 register file: one sync write port and
// one range-guarded combinational read port.
module reg_file_10x4
  import array_pair_responder_pkg::*;
(
  input  logic             Clk,
  input  logic             We,
  input  logic [3:0]       Wa,
  input  logic [WIDTH-1:0] Wd,
  input  logic [3:0]       Ra,
  output logic [WIDTH-1:0] Rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (We && (Wa <= LAST_IDX)) begin
      mem[Wa] <= Wd;
    end
  end

  assign Rd = (Ra <= LAST_IDX) ? mem[Ra] : '0;

endmodule

// File: rtl/array_pair_responder.sv
// Responder holding source M and destination N:
// serial M load, copier write capture, N dump.
module array_pair_responder
  import array_pair_responder_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load_Start,
  input  logic             Load_Valid,
  input  logic [WIDTH-1:0] Load_Data,
  input  logic [3:0]       I,
  output logic [WIDTH-1:0] Ms_of_I,
  input  logic [3:0]       J,
  input  logic             Ns_of_J_Write,
  output logic             Mem_Ready,
  input  logic             Dump_Start,
  output logic             Dump_Valid,
  input  logic             Dump_Ready,
  output logic [WIDTH-1:0] Dump_Data,
  output logic [3:0]       Dump_Index,
  output logic             Dump_Flag,
  output logic             Dump_Last,
  output logic [3:0]       Wr_Cnt,
  output logic             Range_Err,
  output logic             Wr_Err
);

  state_t           state, state_nx;
  logic [3:0]       load_ptr, dump_ptr;
  logic [DEPTH-1:0] nvalid;
  logic [3:0]       wr_cnt;
  logic             range_err, wr_err;
  logic             m_we, n_we;
  logic             in_range, accept;
  logic             serve, dump_go;

  assign in_range = (I <= LAST_IDX) &&
                    (J <= LAST_IDX);
  assign serve    = (state == SERVE);
  assign accept   = Dump_Valid && Dump_Ready;
  assign dump_go  = serve && Dump_Start &&
                    !Load_Start;

  always_comb begin
    state_nx = state;
    m_we     = 1'b0;
    n_we     = 1'b0;
    unique case (1'b1)
      state[0]: begin
        if (Load_Start) state_nx = LOAD;
      end
      state[1]: begin
        m_we = Load_Valid && !Load_Start;
        if (Load_Start) begin
          state_nx = LOAD;
        end else if (m_we &&
                     load_ptr == LAST_IDX) begin
          state_nx = SERVE;
        end
      end
      state[2]: begin
        n_we = Ns_of_J_Write && in_range &&
               !Load_Start;
        if (Load_Start) begin
          state_nx = LOAD;
        end else if (Dump_Start) begin
          state_nx = DUMP;
        end
      end
      state[3]: begin
        if (Load_Start) begin
          state_nx = LOAD;
        end else if (accept &&
                     dump_ptr == LAST_IDX) begin
          state_nx = SERVE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      load_ptr  <= 4'd0;
      dump_ptr  <= 4'd0;
      nvalid    <= '0;
      wr_cnt    <= 4'd0;
      range_err <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state <= state_nx;
      // Every Load_Start enters (or restarts) LOAD
      if (Load_Start) begin
        load_ptr  <= 4'd0;
        nvalid    <= '0;
        wr_cnt    <= 4'd0;
        range_err <= 1'b0;
        wr_err    <= 1'b0;
      end else begin
        if (m_we) load_ptr <= load_ptr + 4'd1;
        if (n_we) begin
          nvalid[J] <= 1'b1;
          if (wr_cnt != 4'hF) begin
            wr_cnt <= wr_cnt + 4'd1;
          end
        end
        if (Ns_of_J_Write && serve && !in_range) begin
          range_err <= 1'b1;
        end
        if (Ns_of_J_Write && !serve) begin
          wr_err <= 1'b1;
        end
      end
      if (dump_go) begin
        dump_ptr <= 4'd0;
      end else if (accept) begin
        dump_ptr <= (dump_ptr == LAST_IDX) ?
                    4'd0 : dump_ptr + 4'd1;
      end
    end
  end

  reg_file_10x4 u_m (
    .Clk (Clk),
    .We  (m_we),
    .Wa  (load_ptr),
    .Wd  (Load_Data),
    .Ra  (I),
    .Rd  (Ms_of_I)
  );

  reg_file_10x4 u_n (
    .Clk (Clk),
    .We  (n_we),
    .Wa  (J),
    .Wd  (Ms_of_I),
    .Ra  (dump_ptr),
    .Rd  (Dump_Data)
  );

  assign Mem_Ready  = serve;
  assign Dump_Valid = (state == DUMP);
  assign Dump_Index = dump_ptr;
  assign Dump_Flag  = (dump_ptr <= LAST_IDX) &&
                      nvalid[dump_ptr];
  assign Dump_Last  = Dump_Valid &&
                      (dump_ptr == LAST_IDX);
  assign Wr_Cnt     = wr_cnt;
  assign Range_Err  = range_err;
  assign Wr_Err     = wr_err;

endmodule

// File: tb/tb_array_pair_responder.sv
// Directed self-checking bench for the
// array_pair_responder.
module tb_array_pair_responder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Load_Start, Load_Valid;
  logic [3:0] Load_Data;
  logic [3:0] I, J;
  logic       Ns_of_J_Write;
  logic [3:0] Ms_of_I;
  logic       Mem_Ready;
  logic       Dump_Start, Dump_Valid, Dump_Ready;
  logic [3:0] Dump_Data, Dump_Index;
  logic       Dump_Flag, Dump_Last;
  logic [3:0] Wr_Cnt;
  logic       Range_Err, Wr_Err;

  int total = 0;
  int bad   = 0;

  logic [3:0] mdat [10] = '{4'h2, 4'h5, 4'h7,
    4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  always #5 Clk = ~Clk;

  array_pair_responder dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Load_Start    (Load_Start),
    .Load_Valid    (Load_Valid),
    .Load_Data     (Load_Data),
    .I             (I),
    .Ms_of_I       (Ms_of_I),
    .J             (J),
    .Ns_of_J_Write (Ns_of_J_Write),
    .Mem_Ready     (Mem_Ready),
    .Dump_Start    (Dump_Start),
    .Dump_Valid    (Dump_Valid),
    .Dump_Ready    (Dump_Ready),
    .Dump_Data     (Dump_Data),
    .Dump_Index    (Dump_Index),
    .Dump_Flag     (Dump_Flag),
    .Dump_Last     (Dump_Last),
    .Wr_Cnt        (Wr_Cnt),
    .Range_Err     (Range_Err),
    .Wr_Err        (Wr_Err)
  );

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  // Full 10-beat load of mdat[k]^x, no gaps
  task automatic load_m(input logic [3:0] x);
    Load_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("ld_rdy_lo", Mem_Ready, 0);
      Load_Valid = 1'b1;
      Load_Data  = mdat[k] ^ x;
      tick();
    end
    Load_Valid = 1'b0;
    chk("ld_rdy_hi", Mem_Ready, 1);
  endtask

  task automatic wr(input logic [3:0] ii,
                    input logic [3:0] jj);
    I = ii;
    J = jj;
    Ns_of_J_Write = 1'b1;
    tick();
    Ns_of_J_Write = 1'b0;
  endtask

  task automatic start_dump();
    Dump_Start = 1'b1;
    tick();
    Dump_Start = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    bit done;
    Reset = 1'b1;
    Load_Start = 0; Load_Valid = 0;
    Load_Data = 0; I = 0; J = 0;
    Ns_of_J_Write = 0; Dump_Start = 0;
    Dump_Ready = 0;
    repeat (2) tick();
    Reset = 1'b0;
    #1;
    chk("rst_rdy",   Mem_Ready,  0);
    chk("rst_dv",    Dump_Valid, 0);
    chk("rst_last",  Dump_Last,  0);
    chk("rst_flag",  Dump_Flag,  0);
    chk("rst_idx",   Dump_Index, 0);
    chk("rst_cnt",   Wr_Cnt,     0);
    chk("rst_rerr",  Range_Err,  0);
    chk("rst_werr",  Wr_Err,     0);

    start_dump();
    chk("idle_dump_ign", Dump_Valid, 0);

    // Load with a 2-cycle gap
    Load_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        Load_Valid = 1'b0;
        repeat (2) begin
          tick();
          chk("gap_rdy", Mem_Ready, 0);
        end
      end
      Load_Valid = 1'b1;
      Load_Data  = mdat[k];
      tick();
      chk("gap_beat_rdy", Mem_Ready, k == 9);
    end
    Load_Valid = 1'b0;
    I = 4'd3; #1;
    chk("m_i3", Ms_of_I, 4'h9);
    I = 4'd12; #1;
    chk("m_i12", Ms_of_I, 4'h0);
    I = 4'd0; #1;
    chk("m_i0", Ms_of_I, 4'h2);

    // Copier: N[0..6] <= M[3..9]
    for (int k = 0; k < 7; k++) begin
      wr(4'(k + 3), 4'(k));
    end
    chk("cnt7", Wr_Cnt, 7);

    start_dump();
    Dump_Ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      #1;
      chk("d_valid", Dump_Valid, 1);
      chk("d_idx",   Dump_Index, b);
      chk("d_flag",  Dump_Flag,  b <= 6);
      chk("d_last",  Dump_Last,  b == 9);
      if (b <= 6) chk("d_data", Dump_Data, mdat[b + 3]);
      tick();
    end
    chk("d_ready_back", Mem_Ready, 1);
    chk("d_done_dv", Dump_Valid, 0);

    // Back-pressure
    start_dump();
    e = 4'd0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      Dump_Ready = c[0];
      #1;
      chk("bp_valid", Dump_Valid, 1);
      chk("bp_idx",   Dump_Index, e);
      chk("bp_flag",  Dump_Flag,  e <= 6);
      chk("bp_last",  Dump_Last,  e == 9);
      if (e <= 6) chk("bp_data", Dump_Data, mdat[e + 3]);
      tick();
      if (c[0]) begin
        if (e == 9) done = 1'b1;
        else e = e + 4'd1;
      end
    end
    Dump_Ready = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_rdy", Mem_Ready, 1);

    // Range error in SERVE
    wr(4'd0, 4'd10);
    chk("rerr_set",  Range_Err, 1);
    chk("rerr_cnt",  Wr_Cnt,    7);
    chk("rerr_werr", Wr_Err,    0);

    // Write during DUMP
    start_dump();
    wr(4'd0, 4'd0);
    #1;
    chk("werr_set",  Wr_Err,     1);
    chk("werr_idx",  Dump_Index, 0);
    chk("werr_n0",   Dump_Data,  4'h9);
    chk("werr_cnt",  Wr_Cnt,     7);
    Dump_Ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      #1;
      chk("w_idx", Dump_Index, b);
      if (b <= 6) chk("w_data", Dump_Data, mdat[b + 3]);
      tick();
    end
    Dump_Ready = 1'b0;
    chk("w_rdy", Mem_Ready, 1);

    // Load_Start clears flags
    Load_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
    chk("clr_rerr", Range_Err, 0);
    chk("clr_werr", Wr_Err,    0);
    chk("clr_cnt",  Wr_Cnt,    0);
    chk("clr_rdy",  Mem_Ready, 0);
    for (int k = 0; k < 10; k++) begin
      Load_Valid = 1'b1;
      Load_Data  = mdat[k];
      tick();
    end
    Load_Valid = 1'b0;
    chk("reload_rdy", Mem_Ready, 1);

    // Simultaneous Load_Start and Dump_Start
    for (int k = 0; k < 5; k++) wr(4'(k), 4'(k));
    chk("sim_cnt5", Wr_Cnt, 5);
    Load_Start = 1'b1;
    Dump_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
    Dump_Start = 1'b0;
    chk("sim_dv",  Dump_Valid, 0);
    chk("sim_rdy", Mem_Ready,  0);
    chk("sim_cnt", Wr_Cnt,     0);
    for (int k = 0; k < 10; k++) begin
      Load_Valid = 1'b1;
      Load_Data  = mdat[k];
      tick();
    end
    Load_Valid = 1'b0;
    chk("sim_load_rdy", Mem_Ready, 1);

    // Saturation then dump abort at beat 4
    for (int k = 0; k < 16; k++) begin
      wr(4'(k % 10), 4'(k % 10));
    end
    chk("sat_cnt", Wr_Cnt, 15);
    start_dump();
    Dump_Ready = 1'b1;
    repeat (4) tick();
    chk("ab_idx4", Dump_Index, 4);
    chk("ab_data4", Dump_Data, mdat[4]);
    Load_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
    Dump_Ready = 1'b0;
    #1;
    chk("ab_dv",   Dump_Valid, 0);
    chk("ab_rdy",  Mem_Ready,  0);
    chk("ab_flag", Dump_Flag,  0);
    chk("ab_cnt",  Wr_Cnt,     0);

    // Reset after 5 load beats
    for (int k = 0; k < 5; k++) begin
      Load_Valid = 1'b1;
      Load_Data  = mdat[k] ^ 4'h5;
      tick();
    end
    Load_Valid = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mr_rdy", Mem_Ready, 0);
    chk("mr_idx", Dump_Index, 0);
    for (int k = 0; k < 5; k++) begin
      Load_Valid = 1'b1;
      Load_Data  = mdat[k] ^ 4'h5;
      tick();
      chk("mr_idle_rdy", Mem_Ready, 0);
    end
    Load_Valid = 1'b0;
    load_m(4'h5);
    I = 4'd1; #1;
    chk("mr_m1", Ms_of_I, 4'h0);
    I = 4'd9; #1;
    chk("mr_m9", Ms_of_I, 4'hA);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
